// File: rtl/ccip_mem_responder_if.sv
// Request/response bundle between a CCI-P style requester and the memory responder.
// Channel 0 carries reads, channel 1 carries writes; almost-full flags flow back.
interface ccip_mem_responder_if;
  logic         c0_req_valid;
  logic [41:0]  c0_req_addr;
  logic [15:0]  c0_req_mdata;

  logic         c1_req_valid;
  logic [41:0]  c1_req_addr;
  logic [511:0] c1_req_data;
  logic [15:0]  c1_req_mdata;

  logic         c0_rsp_valid;
  logic [511:0] c0_rsp_data;
  logic [15:0]  c0_rsp_mdata;

  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;

  logic         c0TxAlmFull;
  logic         c1TxAlmFull;

  modport master (
    output c0_req_valid, c0_req_addr, c0_req_mdata,
    output c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
    input  c0_rsp_valid, c0_rsp_data, c0_rsp_mdata,
    input  c1_rsp_valid, c1_rsp_mdata,
    input  c0TxAlmFull, c1TxAlmFull
  );

  modport slave (
    input  c0_req_valid, c0_req_addr, c0_req_mdata,
    input  c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
    output c0_rsp_valid, c0_rsp_data, c0_rsp_mdata,
    output c1_rsp_valid, c1_rsp_mdata,
    output c0TxAlmFull, c1TxAlmFull
  );
endinterface

// File: rtl/ccip_mem_responder.sv
// Cache-line memory model answering CCI-P style reads and writes.
// Reads go through a FIFO (addr+tag) and a fixed-depth RAM read pipeline so the
// response lands RD_LATENCY cycles after acceptance at the earliest. Writes commit
// at their accept edge and are acknowledged two cycles later, so a read accepted
// in the same or a later cycle always sees them.
module ccip_mem_responder #(
  parameter int ADDR_BITS  = 10,
  parameter int RD_LATENCY = 3,
  parameter int QDEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 soft_reset,
  input  logic                 rd_stall,
  ccip_mem_responder_if.slave  bus,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count,
  output logic                 overflow
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int PW    = $clog2(QDEPTH);
  // Stage 0 captures the RAM read at the pop edge; the last stage drives c0.
  localparam int NST   = RD_LATENCY - 1;
  localparam logic [PW:0] Q_FULL = (PW+1)'(QDEPTH);
  localparam logic [PW:0] Q_ALM  = (PW+1)'(QDEPTH - 4);

  logic [511:0]          mem [DEPTH];

  logic [ADDR_BITS-1:0]  q_addr  [QDEPTH];
  logic [15:0]           q_mdata [QDEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           q_count, q_count_next;
  logic                  q_full, push, pop;
  logic                  alm_full_q;

  logic [NST-1:0]        pipe_v;
  logic [15:0]           pipe_md [NST];
  logic [511:0]          pipe_d  [NST];

  logic                  wr_v1, wr_v2;
  logic [15:0]           wr_md1, wr_md2;

  logic [ADDR_BITS-1:0]  wr_line;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same line by design.
  assign unused_addr_hi = ^{bus.c0_req_addr[41:ADDR_BITS], bus.c1_req_addr[41:ADDR_BITS]};
  assign wr_line        = bus.c1_req_addr[ADDR_BITS-1:0];

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign q_full = (q_count == Q_FULL);
  assign push   = bus.c0_req_valid && !q_full;
  assign pop    = (q_count != '0) && !rd_stall;

  // Next occupancy after this edge's push/pop.
  always_comb begin
    q_count_next = q_count;
    if (push && !pop) begin
      q_count_next = q_count + (PW+1)'(1);
    end else if (!push && pop) begin
      q_count_next = q_count - (PW+1)'(1);
    end
  end

  // Read queue pointers, occupancy, almost-full flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_count    <= '0;
      alm_full_q <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_count    <= q_count_next;
      alm_full_q <= (q_count_next >= Q_ALM);
      if (bus.c0_req_valid && q_full) overflow <= 1'b1;
    end
  end

  // Queue storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= bus.c0_req_addr[ADDR_BITS-1:0];
      q_mdata[wr_ptr] <= bus.c0_req_mdata;
    end
  end

  // RAM write port; contents survive soft_reset.
  always_ff @(posedge clk) begin
    if (!soft_reset && bus.c1_req_valid) begin
      mem[wr_line] <= bus.c1_req_data;
    end
  end

  // Read pipeline valid bits; cleared on reset so no stale response escapes.
  always_ff @(posedge clk) begin
    if (soft_reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= pop;
      for (int k = 1; k < NST; k++) begin
        pipe_v[k] <= pipe_v[k-1];
      end
    end
  end

  // RAM read at the pop edge, then shifted toward the response stage.
  always_ff @(posedge clk) begin
    if (pop) begin
      pipe_d[0]  <= mem[q_addr[rd_ptr]];
      pipe_md[0] <= q_mdata[rd_ptr];
    end
    for (int k = 1; k < NST; k++) begin
      pipe_d[k]  <= pipe_d[k-1];
      pipe_md[k] <= pipe_md[k-1];
    end
  end

  // Write acknowledge: two register stages after the accept edge.
  always_ff @(posedge clk) begin
    if (soft_reset) begin
      wr_v1 <= 1'b0;
      wr_v2 <= 1'b0;
    end else begin
      wr_v1  <= bus.c1_req_valid;
      wr_v2  <= wr_v1;
      wr_md1 <= bus.c1_req_mdata;
      wr_md2 <= wr_md1;
    end
  end

  // Completed-response counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (soft_reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (pipe_v[NST-1]) rd_count <= rd_count + 32'd1;
      if (wr_v2)         wr_count <= wr_count + 32'd1;
    end
  end

  assign bus.c0_rsp_valid = pipe_v[NST-1];
  assign bus.c0_rsp_data  = pipe_d[NST-1];
  assign bus.c0_rsp_mdata = pipe_md[NST-1];
  assign bus.c1_rsp_valid = wr_v2;
  assign bus.c1_rsp_mdata = wr_md2;
  assign bus.c0TxAlmFull  = alm_full_q;
  assign bus.c1TxAlmFull  = 1'b0;

endmodule

// File: tb/tb_ccip_mem_responder.sv
// Bench for ccip_mem_responder: directed scenarios plus a randomized mix, all
// checked against a behavioural model (line-indexed memory, expected-response
// queues with due cycles, and an occupancy counter for the read queue).
module tb_ccip_mem_responder;
  localparam int ADDR_BITS  = 10;
  localparam int RD_LATENCY = 3;
  localparam int QDEPTH     = 16;
  localparam int DEPTH      = 1 << ADDR_BITS;

  logic        clk = 1'b0;
  logic        soft_reset;
  logic        rd_stall;
  logic [31:0] rd_count, wr_count;
  logic        overflow;

  ccip_mem_responder_if bus();

  ccip_mem_responder #(
    .ADDR_BITS (ADDR_BITS),
    .RD_LATENCY(RD_LATENCY),
    .QDEPTH    (QDEPTH)
  ) dut (
    .clk       (clk),
    .soft_reset(soft_reset),
    .rd_stall  (rd_stall),
    .bus       (bus),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int line; logic [15:0] md; logic [511:0] d; } rexp_t;
  typedef struct { int due; logic [15:0] md; } wexp_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           tmode;
  int           last_due;
  int           occ;
  bit           ovf_exp;
  int           n_c0;
  int           n_mark;
  logic [511:0] mm [int];
  int           pending [int];
  rexp_t        rq [$];
  wexp_t        wq [$];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic set_idle();
    bus.c0_req_valid = 1'b0;
    bus.c0_req_addr  = '0;
    bus.c0_req_mdata = '0;
    bus.c1_req_valid = 1'b0;
    bus.c1_req_addr  = '0;
    bus.c1_req_data  = '0;
    bus.c1_req_mdata = '0;
  endtask

  task automatic drive_rd(input logic [41:0] a, input logic [15:0] md);
    bus.c0_req_valid = 1'b1;
    bus.c0_req_addr  = a;
    bus.c0_req_mdata = md;
  endtask

  task automatic drive_wr(input logic [41:0] a, input logic [511:0] d, input logic [15:0] md);
    bus.c1_req_valid = 1'b1;
    bus.c1_req_addr  = a;
    bus.c1_req_data  = d;
    bus.c1_req_mdata = md;
  endtask

  // One clock: update the model with what the DUT accepts at this edge, then check outputs.
  task automatic step();
    rexp_t e;
    wexp_t w;
    int    line;
    bit    pop_now, was_reset, exp_v;
    was_reset = soft_reset;
    if (soft_reset) begin
      rq.delete(); wq.delete(); pending.delete();
      occ = 0; ovf_exp = 1'b0; last_due = 0;
    end else begin
      if (bus.c1_req_valid) begin
        line = int'(bus.c1_req_addr % DEPTH);
        mm[line] = bus.c1_req_data;
        w.due = cyc + 2; w.md = bus.c1_req_mdata;
        wq.push_back(w);
      end
      pop_now = (occ > 0) && !rd_stall;
      if (bus.c0_req_valid) begin
        if (occ >= QDEPTH) ovf_exp = 1'b1;
        else begin
          line = int'(bus.c0_req_addr % DEPTH);
          e.line = line; e.md = bus.c0_req_mdata; e.d = mm[line];
          if (tmode) begin
            e.due = (cyc + RD_LATENCY > last_due + 1) ? cyc + RD_LATENCY : last_due + 1;
            last_due = e.due;
          end else e.due = -1;
          rq.push_back(e);
          pending[line] = pending[line] + 1;
          occ++;
        end
      end
      if (pop_now) occ--;
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("c0TxAlmFull", bus.c0TxAlmFull, occ >= QDEPTH - 4);
    chk("overflow", overflow, ovf_exp);
    chk("c1TxAlmFull", bus.c1TxAlmFull, 1'b0);
    if (was_reset) begin
      chk("rd_count_reset", rd_count, 0);
      chk("wr_count_reset", wr_count, 0);
    end
    exp_v = (wq.size() > 0) && (wq[0].due == cyc);
    chk("c1_rsp_valid", bus.c1_rsp_valid, exp_v);
    if (exp_v) begin
      w = wq.pop_front();
      if (bus.c1_rsp_valid === 1'b1) chk("c1_rsp_mdata", bus.c1_rsp_mdata, w.md);
    end
    if (bus.c0_rsp_valid === 1'b1) n_c0++;
    if (tmode) exp_v = (rq.size() > 0) && (rq[0].due == cyc);
    else       exp_v = (rq.size() > 0) && (bus.c0_rsp_valid === 1'b1);
    chk("c0_rsp_valid", bus.c0_rsp_valid, exp_v);
    if (exp_v) begin
      e = rq.pop_front();
      pending[e.line] = pending[e.line] - 1;
      if (bus.c0_rsp_valid === 1'b1) begin
        chk("c0_rsp_mdata", bus.c0_rsp_mdata, e.md);
        chk("c0_rsp_data", bus.c0_rsp_data, e.d);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    set_idle();
    rd_stall = 1'b0;
    while ((rq.size() > 0 || wq.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_c0_outstanding", rq.size(), 0);
    chk("drain_c1_outstanding", wq.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] da;
    int           ln;
    soft_reset = 1'b1;
    rd_stall   = 1'b0;
    tmode      = 1'b1;
    n_c0       = 0;
    set_idle();
    repeat (3) step();
    soft_reset = 1'b0;

    // Preload lines 0..31, back to back.
    for (int i = 0; i < 32; i++) begin
      set_idle();
      drive_wr(42'(i), rnd512(), 16'(16'h0100 + i));
      step();
    end
    drain(20);

    // Write 0x5 then read 0x5 one cycle later.
    set_idle();
    drive_wr(42'h5, rnd512(), 16'h0011);
    step();
    set_idle();
    drive_rd(42'h5, 16'h0038);
    step();
    drain(20);

    // Same-cycle write and read on line 0x7.
    set_idle();
    drive_wr(42'h7, rnd512(), 16'h0039);
    drive_rd(42'h7, 16'h3939);
    step();
    drain(20);

    // Aliasing: write 0x405, read back through 0x005.
    set_idle();
    drive_wr(42'h405, rnd512(), 16'h0042);
    step();
    set_idle();
    drive_rd(42'h005, 16'h4242);
    step();
    drain(20);

    // Fresh counters, then 20 back-to-back reads.
    soft_reset = 1'b1;
    set_idle();
    step();
    soft_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_idle();
      drive_rd(42'($urandom_range(0, 31)), 16'(16'h2000 + i));
      step();
    end
    drain(40);
    chk("rd_count_after_20", rd_count, 20);
    chk("wr_count_after_20", wr_count, 0);

    // Stall the queue and push 17 reads: almost-full after 12, 17th dropped.
    tmode = 1'b0;
    rd_stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_idle();
      drive_rd(42'(i), 16'(16'h3000 + i));
      step();
      if (i == 10) chk("almfull_after_11", bus.c0TxAlmFull, 1'b0);
      if (i == 11) chk("almfull_after_12", bus.c0TxAlmFull, 1'b1);
    end
    chk("overflow_after_17", overflow, 1'b1);
    n_mark = n_c0;
    drain(60);
    chk("responses_after_release", n_c0 - n_mark, 16);
    chk("rd_count_after_release", rd_count, 36);

    // Randomized mix: stalls, reads, writes; writes avoid lines with reads in flight.
    for (int i = 0; i < 300; i++) begin
      set_idle();
      rd_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        ln = $urandom_range(0, 31);
        if (pending[ln] == 0)
          drive_wr(42'(ln) + (42'($urandom_range(0, 3)) << ADDR_BITS), rnd512(), 16'($urandom()));
      end
      if ($urandom_range(0, 1) == 1 && rq.size() < 8)
        drive_rd(42'($urandom_range(0, 31)) + (42'($urandom_range(0, 3)) << ADDR_BITS), 16'($urandom()));
      step();
    end
    drain(60);

    // Reset with five reads parked in the stalled queue.
    da = mm[3];
    rd_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      drive_rd(42'(i), 16'(16'h5000 + i));
      step();
    end
    set_idle();
    soft_reset = 1'b1;
    repeat (2) step();
    soft_reset = 1'b0;
    rd_stall = 1'b0;
    tmode = 1'b1;
    n_mark = n_c0;
    drive_rd(42'h3, 16'hBEEF);
    step();
    set_idle();
    drain(20);
    repeat (5) step();
    chk("responses_after_reset", n_c0 - n_mark, 1);
    chk("ram_retained_model", mm[3], da);
    chk("rd_count_after_reset", rd_count, 1);
    chk("wr_count_after_reset", wr_count, 0);
    chk("overflow_after_reset", overflow, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccip_mem_responder.md
CCIP_MEM_RESPONDER -- requirements
Module: ccip_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, memory depth of 2^ADDR_BITS 512-bit lines.
REQ-002 SHALL have parameter RD_LATENCY, default 3, minimum read request-to-response cycles; legal range 2..8.
REQ-003 SHALL have parameter QDEPTH, default 16, read queue entries; power of 2, >= 8.
REQ-004 clk  in  1  sole clock, all state on posedge.
REQ-005 soft_reset  in  1  synchronous, active-high reset.
REQ-006 c0_req_valid  in  1  read request strobe.
REQ-007 c0_req_addr  in  42  read cache-line address.
REQ-008 c0_req_mdata  in  16  read tag.
REQ-009 c1_req_valid  in  1  write request strobe.
REQ-010 c1_req_addr  in  42  write cache-line address.
REQ-011 c1_req_data  in  512  write data.
REQ-012 c1_req_mdata  in  16  write tag.
REQ-013 rd_stall  in  1  backpressure injection; holds read queue.
REQ-014 c0_rsp_valid  out  1  read response strobe.
REQ-015 c0_rsp_data  out  512  read data.
REQ-016 c0_rsp_mdata  out  16  echoed read tag.
REQ-017 c1_rsp_valid  out  1  write response strobe.
REQ-018 c1_rsp_mdata  out  16  echoed write tag.
REQ-019 c0TxAlmFull  out  1  read queue nearly full.
REQ-020 c1TxAlmFull  out  1  constant 0.
REQ-021 rd_count / wr_count  out  32 each  completed responses per channel.
REQ-022 overflow  out  1  sticky: read request dropped.

Function
REQ-023 Line index SHALL be addr[ADDR_BITS-1:0]; upper address bits ignored (aliasing, not an error).
REQ-024 Read accepted at cycle T (c0_req_valid=1, queue not full) SHALL enter a FIFO queue holding addr+mdata.
REQ-025 One queue entry SHALL pop per cycle when non-empty and rd_stall=0; none pop while rd_stall=1.
REQ-026 Response SHALL appear at cycle max(T+RD_LATENCY, previous c0 response+1) when rd_stall stays 0; responses in acceptance order, one per cycle max.
REQ-027 Data for a popped entry SHALL be read from RAM no earlier than the edge ending cycle T+1.
REQ-028 Write accepted at cycle T SHALL commit to RAM at the edge ending T; c1_rsp_valid with mdata at cycle T+2; no write backpressure.
REQ-029 Ordering: a read SHALL return data of every write accepted in the same or earlier cycle to that line (write-before-read).
REQ-030 c0 and c1 responses SHALL be independent; both may be valid in the same cycle.
REQ-031 c0TxAlmFull SHALL be registered, high when occupancy >= QDEPTH-4 at previous edge.
REQ-032 Read arriving while queue holds QDEPTH entries SHALL be dropped, overflow set until reset; a simultaneous pop does not free a slot that cycle.
REQ-033 rd_count/wr_count SHALL increment on each response cycle, wrap 2^32-1 -> 0.
REQ-034 Response data/mdata SHALL be don't-care when the corresponding valid is 0.

Reset
REQ-035 While soft_reset=1: c0_rsp_valid, c1_rsp_valid, c0TxAlmFull, overflow = 0; counters = 0; queue and in-flight pipeline emptied; requests ignored.
REQ-036 Responses for requests accepted before reset SHALL never appear after reset; RAM contents SHALL be retained, not cleared.
REQ-037 First request accepted in the cycle after soft_reset deasserts SHALL be serviced normally.

Verification
REQ-038 Write addr 0x5 data A, mdata 0x11 at T -> c1_rsp_valid, mdata 0x11 at T+2; read 0x5 at T+1 -> data A at T+4.
REQ-039 Same-cycle write B and read, addr 0x7 -> read returns B; both channels respond independently.
REQ-040 20 back-to-back reads, rd_stall=0 -> first response at T+3, then 20 consecutive cycles, mdata in order, rd_count=20.
REQ-041 rd_stall=1, 17 reads -> c0TxAlmFull high after 12th, 17th dropped, overflow=1; release -> exactly 16 responses.
REQ-042 Write addr 0x405 (ADDR_BITS=10), read 0x005 -> aliased data returned.
REQ-043 Reset with 5 reads queued -> no c0 response afterwards, counters 0, prior RAM data still readable.
